// File: rtl/enc_pkg.sv
// Shared definitions for the RISC-V immediate encoder: format codes and the
// instruction width used by both the encode and decode sides.
package enc_pkg;

    localparam int INSTR_W = 32;

    typedef enum logic [2:0] {
        FMT_I = 3'b000,
        FMT_S = 3'b001,
        FMT_B = 3'b010,
        FMT_U = 3'b011,
        FMT_J = 3'b100
    } fmt_t;

endpackage

// File: rtl/imm_pack.sv
// Combinational immediate packer: scatters imm into the bit positions of the
// selected format on top of base. Optional range check under RANGE_CHECK_EN.
module imm_pack
    import enc_pkg::*;
#(
    parameter int WIDTH = INSTR_W
) (
    input  logic [2:0]       fmt,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] base,
    output logic [WIDTH-1:0] instr,
    output logic             err
);

`ifdef RANGE_CHECK_EN
    // True when v survives truncation to 'bits' bits followed by sign extension.
    function automatic logic fits_signed(input logic signed [WIDTH-1:0] v, input int bits);
        logic signed [WIDTH-1:0] ext;
        ext = (v <<< (WIDTH - bits)) >>> (WIDTH - bits);
        return ext == v;
    endfunction

    logic signed [WIDTH-1:0] imm_s;
    assign imm_s = $signed(imm);
`endif

    logic [WIDTH-1:0] packed_word;
    logic             legal;
    logic             in_range;

    always_comb begin
        packed_word = base;
        legal       = 1'b1;
        in_range    = 1'b1;
        case (fmt)
            FMT_I: begin
                packed_word = {imm[11:0], base[19:0]};
`ifdef RANGE_CHECK_EN
                in_range = fits_signed(imm_s, 12);
`endif
            end
            FMT_S: begin
                packed_word = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
`ifdef RANGE_CHECK_EN
                in_range = fits_signed(imm_s, 12);
`endif
            end
            FMT_B: begin
                packed_word = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
`ifdef RANGE_CHECK_EN
                in_range = fits_signed(imm_s, 13) && !imm[0];
`endif
            end
            FMT_U: begin
                packed_word = {imm[31:12], base[11:0]};
`ifdef RANGE_CHECK_EN
                in_range = (imm[11:0] == 12'd0);
`endif
            end
            FMT_J: begin
                packed_word = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
`ifdef RANGE_CHECK_EN
                in_range = fits_signed(imm_s, 21) && !imm[0];
`endif
            end
            default: legal = 1'b0;
        endcase
        // A flagged word passes the template through untouched.
        err   = !legal || !in_range;
        instr = err ? base : packed_word;
    end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage pipelined RISC-V immediate encoder with valid/ready on both sides.
// Define RANGE_CHECK_EN to flag immediates that do not fit their format.
module instr_encoder
    import enc_pkg::*;
#(
    parameter int WIDTH = INSTR_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       fmt,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] instr,
    output logic             err,
    output logic [CNT_W-1:0] enc_count
);

    logic             vld_p0;
    logic [2:0]       fmt_p0;
    logic [WIDTH-1:0] imm_p0;
    logic [WIDTH-1:0] base_p0;

    logic             vld_p1;
    logic [WIDTH-1:0] instr_p1;
    logic             err_p1;

    logic [WIDTH-1:0] pack_instr;
    logic             pack_err;
    logic             adv_p1;

    assign adv_p1   = !vld_p1 || out_ready;
    assign in_ready = !vld_p0 || adv_p1;

    // Stage A: capture the raw request
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            fmt_p0  <= fmt;
            imm_p0  <= imm;
            base_p0 <= base;
        end
    end

    imm_pack #(
        .WIDTH(WIDTH)
    ) u_imm_pack (
        .fmt  (fmt_p0),
        .imm  (imm_p0),
        .base (base_p0),
        .instr(pack_instr),
        .err  (pack_err)
    );

    // Stage B: encoded word, held while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            instr_p1  <= '0;
            err_p1    <= 1'b0;
            enc_count <= '0;
        end else begin
            if (in_ready) vld_p0 <= in_valid;
            if (adv_p1) begin
                vld_p1 <= vld_p0;
                if (vld_p0) begin
                    instr_p1 <= pack_instr;
                    err_p1   <= pack_err;
                end
            end
            if (vld_p1 && out_ready) enc_count <= enc_count + CNT_W'(1);
        end
    end

    assign out_valid = vld_p1;
    assign instr     = instr_p1;
    assign err       = err_p1;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized self-checking bench for instr_encoder with a scoreboard fed by an
// arithmetic reference model; follows RANGE_CHECK_EN if it is defined.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic [31:0] base;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        err;
    logic [15:0] enc_count;

    int          n_checks = 0;
    int          n_errs   = 0;
    logic [32:0] exp_q[$];
    logic [15:0] exp_cnt  = 16'd0;
    logic        held_v   = 1'b0;
    logic [31:0] held_instr;
    logic        held_err;
    bit          stop_rand;

`ifdef RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    instr_encoder dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .fmt      (fmt),
        .imm      (imm),
        .base     (base),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .instr    (instr),
        .err      (err),
        .enc_count(enc_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: {err, instr} computed with masks, shifts and integer ranges.
    function automatic logic [32:0] model(input logic [2:0] f, input logic [31:0] i, input logic [31:0] b);
        logic [31:0] m, v;
        longint      s;
        bit          ok, legal;
        s = longint'($signed(i));
        m = 32'd0; v = 32'd0; ok = 1; legal = 1;
        case (f)
            3'd0: begin
                m = 32'hFFF0_0000; v = (i & 32'hFFF) << 20;
                ok = (s >= -2048) && (s <= 2047);
            end
            3'd1: begin
                m = 32'hFE00_0F80; v = (((i >> 5) & 32'h7F) << 25) | ((i & 32'h1F) << 7);
                ok = (s >= -2048) && (s <= 2047);
            end
            3'd2: begin
                m = 32'hFE00_0F80;
                v = (((i >> 12) & 1) << 31) | (((i >> 5) & 32'h3F) << 25) |
                    (((i >> 1) & 32'hF) << 8) | (((i >> 11) & 1) << 7);
                ok = (s >= -4096) && (s <= 4095) && (i % 2 == 0);
            end
            3'd3: begin
                m = 32'hFFFF_F000; v = i & 32'hFFFF_F000;
                ok = (i % 4096 == 0);
            end
            3'd4: begin
                m = 32'hFFFF_F000;
                v = (((i >> 20) & 1) << 31) | (((i >> 1) & 32'h3FF) << 21) |
                    (((i >> 11) & 1) << 20) | (((i >> 12) & 32'hFF) << 12);
                ok = (s >= -(64'sd1 << 20)) && (s < (64'sd1 << 20)) && (i % 2 == 0);
            end
            default: legal = 0;
        endcase
        if (!legal || (RC && !ok)) return {1'b1, b};
        return {1'b0, (b & ~m) | v};
    endfunction

    // Scoreboard and output-stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_instr", 64'(instr), 64'(held_instr));
                check("hold_err", 64'(err), 64'(held_err));
            end
            check("enc_count", 64'(enc_count), 64'(exp_cnt));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'd1, 64'd0);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    check("instr", 64'(instr), 64'(e[31:0]));
                    check("err", 64'(err), 64'(e[32]));
                end
                exp_cnt = exp_cnt + 16'd1;
            end
            if (in_valid && in_ready) exp_q.push_back(model(fmt, imm, base));
            held_v     = out_valid && !out_ready;
            held_instr = instr;
            held_err   = err;
        end
    end

    task automatic send(input logic [2:0] f, input logic [31:0] i, input logic [31:0] b);
        int n = 0;
        fmt = f; imm = i; base = b; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready) begin
            n++;
            if (n > 100) begin
                check("send_timeout", 64'd1, 64'd0);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Single word into an empty pipeline: valid must rise on the second edge.
    task automatic directed(input logic [2:0] f, input logic [31:0] i, input logic [31:0] b);
        send(f, i, b);
        @(negedge clk);
        check("lat_early", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("lat_due", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0: ;
            1: r = 32'($signed(r) >>> 19);
            2: r = r & 32'hFFFF_F000;
            default: r = 32'($signed(r) >>> 11) & ~32'd1;
        endcase
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        fmt = 3'd0; imm = 32'd0; base = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_count", 64'(enc_count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        directed(3'd0, 32'hFFFF_FFFF, 32'h0000_0013);
        directed(3'd1, 32'h0000_0008, 32'h0000_2023);
        directed(3'd2, 32'hFFFF_FFFC, 32'h0000_0063);
        directed(3'd4, 32'h0000_0800, 32'h0000_006F);
        directed(3'd3, 32'h1234_5000, 32'h0000_0037);
        directed(3'd5, 32'h0000_0004, 32'h0000_1234);
        directed(3'd7, 32'h0000_0000, 32'hDEAD_BEEF);
        directed(3'd0, 32'h0000_0800, 32'h0000_0013);
        directed(3'd2, 32'h0000_0003, 32'h0000_0063);

        // Full-rate stream with the consumer always ready.
        for (int k = 0; k < 150; k++) begin
            send(3'($urandom_range(0, 7)), rand_imm(), $urandom);
            check("stream_in_ready", 64'(in_ready), 64'd1);
        end
        drain();

        // Back-pressure: four words against a consumer stalled for three cycles.
        rst = 1'b1;
        #1 rst = 1'b0;
        exp_q.delete(); exp_cnt = 16'd0;
        @(posedge clk);
        #1 out_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 4; k++) send(3'($urandom_range(0, 4)), rand_imm(), $urandom);
            end
            begin
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                check("bp_in_ready", 64'(in_ready), 64'd0);
                check("bp_out_valid", 64'(out_valid), 64'd1);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", 64'(enc_count), 64'd4);

        // Random valid and ready patterns on both sides.
        stop_rand = 1'b0;
        fork
            begin
                for (int k = 0; k < 250; k++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(3'($urandom_range(0, 7)), rand_imm(), $urandom);
                end
                stop_rand = 1'b1;
            end
            begin
                while (!stop_rand) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        drain();

        // Reset with the pipeline full discards both words at once.
        out_ready = 1'b0;
        send(3'd0, 32'd5, 32'h13);
        send(3'd3, 32'hABCD_E000, 32'h37);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_count", 64'(enc_count), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete(); exp_cnt = 16'd0;
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        directed(3'd1, 32'hFFFF_FFF0, 32'h0000_2023);
        drain();
        check("post_rst_count", 64'(enc_count), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
